four_bit_multiplier: RTL and testbench



---
 rtl/four_bit_multiplier.sv | 113 +++++++++++
 tb/tb_four_bit_multiplier.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/four_bit_multiplier.sv
// rtl/four_bit_multiplier.sv - unsigned 4x4 array multiplier with registered product and valid tag
// Optional input register stage enabled by defining FOUR_BIT_MULT_INREG_EN.

module four_bit_mult_fa (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ z;
  assign co = (x & y) | ((x ^ y) & z);
endmodule

module four_bit_mult_row (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [3:0] s,
  output logic       co
);
  logic [4:0] cy;

  assign cy[0] = 1'b0;

  for (genvar k = 0; k < 4; k++) begin : g_bit
    four_bit_mult_fa u_fa (
      .x  (x[k]),
      .y  (y[k]),
      .z  (cy[k]),
      .s  (s[k]),
      .co (cy[k+1])
    );
  end

  assign co = cy[4];
endmodule

module four_bit_multiplier (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       in_valid,
  output logic [7:0] c,
  output logic       out_valid
);
  logic [3:0] a_arr;
  logic [3:0] b_arr;
  logic       v_arr;

`ifdef FOUR_BIT_MULT_INREG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      a_arr <= 4'h0;
      b_arr <= 4'h0;
      v_arr <= 1'b0;
    end else begin
      a_arr <= a;
      b_arr <= b;
      v_arr <= in_valid;
    end
  end
`else
  assign a_arr = a;
  assign b_arr = b;
  assign v_arr = in_valid;
`endif

  // pp[i][j] = a[i] & b[j]
  logic [3:0] pp [4];
  for (genvar i = 0; i < 4; i++) begin : g_pp
    assign pp[i] = {4{a_arr[i]}} & b_arr;
  end

  logic [3:0] s0, s1, s2;
  logic       co0, co1, co2;

  four_bit_mult_row u_row0 (
    .x  ({1'b0, pp[0][3:1]}),
    .y  (pp[1]),
    .s  (s0),
    .co (co0)
  );

  four_bit_mult_row u_row1 (
    .x  ({co0, s0[3:1]}),
    .y  (pp[2]),
    .s  (s1),
    .co (co1)
  );

  four_bit_mult_row u_row2 (
    .x  ({co1, s1[3:1]}),
    .y  (pp[3]),
    .s  (s2),
    .co (co2)
  );

  logic [7:0] product;
  assign product = {co2, s2, s1[0], s0[0], pp[0][0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      c         <= 8'h00;
      out_valid <= 1'b0;
    end else begin
      out_valid <= v_arr;
      if (v_arr) begin
        c <= product;
      end
    end
  end
endmodule

// File: tb/tb_four_bit_multiplier.sv
// tb/tb_four_bit_multiplier.sv - self-checking bench for four_bit_multiplier
// Latency follows FOUR_BIT_MULT_INREG_EN.

module tb_four_bit_multiplier;
`ifdef FOUR_BIT_MULT_INREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic       in_valid;
  logic [7:0] c;
  logic       out_valid;

  four_bit_multiplier dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .c         (c),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;
  bit chk_en   = 1'b0;

  typedef struct {
    logic       v;
    logic [7:0] p;
  } entry_t;

  entry_t     q[$];
  logic [7:0] exp_c;
  logic       exp_v;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d required %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    entry_t e;
    q.delete();
    e.v = 1'b0;
    e.p = 8'h00;
    for (int k = 0; k < LAT - 1; k++) q.push_back(e);
    exp_c = 8'h00;
    exp_v = 1'b0;
  endtask

  // Reference: product of sampled operands appears LAT edges later; c holds otherwise
  always @(posedge clk) begin
    entry_t e;
    if (rst) begin
      model_reset();
    end else begin
      e.v = in_valid;
      e.p = 8'(int'(a) * int'(b));
      q.push_back(e);
      e = q.pop_front();
      exp_v = e.v;
      if (e.v) exp_c = e.p;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("stream_valid", {7'b0, out_valid}, {7'b0, exp_v});
      check("stream_c", c, exp_c);
      if (out_valid) pulses++;
    end
  end

  task automatic drive(input logic r, input logic [3:0] x, input logic [3:0] y, input logic v);
    rst = r;
    a = x;
    b = y;
    in_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    for (int k = 0; k < LAT - 1; k++) drive(1'b0, 4'h0, 4'h0, 1'b0);
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] p;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{a: 4'd0,  b: 4'd15, p: 8'd0};
    vecs[1] = '{a: 4'd15, b: 4'd1,  p: 8'd15};
    vecs[2] = '{a: 4'd8,  b: 4'd8,  p: 8'h40};
    vecs[3] = '{a: 4'd15, b: 4'd15, p: 8'hE1};
    vecs[4] = '{a: 4'd5,  b: 4'd3,  p: 8'd15};

    // Reset held two cycles with live operands
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 4'hF, 4'hF, 1'b1);
      check("reset_c", c, 8'h00);
      check("reset_valid", {7'b0, out_valid}, 8'h00);
    end
    chk_en = 1'b1;

    // Corner table
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, vecs[i].a, vecs[i].b, 1'b1);
      flush();
      check($sformatf("corner_%0dx%0d", vecs[i].a, vecs[i].b), c, vecs[i].p);
      check("corner_valid", {7'b0, out_valid}, 8'h01);
    end
    drive(1'b0, 4'h0, 4'h0, 1'b0);

    // Exhaustive back-to-back sweep
    pulses = 0;
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        drive(1'b0, 4'(x), 4'(y), 1'b1);
    for (int k = 0; k < LAT; k++) drive(1'b0, 4'h0, 4'h0, 1'b0);
    #4;
    check("sweep_pulses", 8'(pulses), 8'(256 % 256));
    check("sweep_last_c", c, 8'hE1);
    drive(1'b0, 4'h0, 4'h0, 1'b0);

    // Hold: idle cycles with changing operands keep c
    drive(1'b0, 4'd7, 4'd9, 1'b1);
    flush();
    check("hold_first", c, 8'd63);
    for (int k = 0; k < LAT + 1; k++) begin
      drive(1'b0, 4'd3, 4'd3, 1'b0);
      check("hold_c", c, 8'd63);
      check("hold_valid", {7'b0, out_valid}, 8'h00);
    end

    // Reset at the same edge as an issued operand pair
    drive(1'b1, 4'd12, 4'd11, 1'b1);
    check("midrst_c", c, 8'h00);
    check("midrst_valid", {7'b0, out_valid}, 8'h00);
    drive(1'b0, 4'd2, 4'd3, 1'b1);
    if (LAT == 2) check("midrst_lat_valid", {7'b0, out_valid}, 8'h00);
    flush();
    check("after_rst_c", c, 8'd6);
    check("after_rst_valid", {7'b0, out_valid}, 8'h01);

    // Random traffic with occasional resets
    for (int k = 0; k < 400; k++) begin
      drive(($urandom_range(0, 19) == 0), 4'($urandom), 4'($urandom), 1'($urandom));
    end
    drive(1'b0, 4'h0, 4'h0, 1'b0);
    drive(1'b0, 4'h0, 4'h0, 1'b0);
    #4;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
